// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Bundles the signals between the fetch stage and its neighbours: the byte-wide
// program memory port and the decoder/execute side.
//
// Handshakes (strict valid/ready semantics):
//   - Memory: a byte transfers on every rising edge where mem_req & mem_ready.
//     While mem_req is high and mem_ready is low, mem_addr is held constant.
//   - Decoder/execute: inst is held stable while inst_valid is high. execute
//     consumes it with exec_done, which is sampled only while inst_valid.
//     redirect/redirect_pc/halt qualify exec_done.
//
// Modports:
//   master - fetch unit view (drives memory request and instruction outputs)
//   slave  - environment view (memory plus decoder/execute)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] inst_pc;
    logic [15:0] next_pc;
    logic        exec_done;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;

    modport master (
        output mem_req, mem_addr, inst, inst_valid, inst_pc, next_pc, halted,
        input  mem_ready, mem_rdata, exec_done, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr, inst, inst_valid, inst_pc, next_pc, halted,
        output mem_ready, mem_rdata, exec_done, redirect, redirect_pc, halt
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Reads an opcode byte (and an argument byte when
// opcode[7] is set) from program memory, presents the 16-bit word
// {opcode, arg or 8'h00} with inst_valid, and holds it until execute reports
// completion. Then continues sequentially, at a redirect target, or halts.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   bus          fetch_unit_if.master (memory port + decoder/execute signals)
//   dbg_state_o  current FSM state (FETCH_OP=0, FETCH_ARG=1, HOLD=2, HALTED=3)
//   perf_inst_count_o / perf_stall_count_o  only with FETCH_PERF_COUNT_EN
//
// Optional feature macro: FETCH_PERF_COUNT_EN
//   Adds a count of accepted exec_done and a count of memory stall cycles
//   (mem_req & !mem_ready). Both are 16-bit wrapping counters reset to 0.
//
// All outputs are registered. pc arithmetic wraps modulo 2^16.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      bus,
`ifdef FETCH_PERF_COUNT_EN
    output logic [15:0]       perf_inst_count_o,
    output logic [15:0]       perf_stall_count_o,
`endif
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2,
        HALTED    = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] inst_q;
    logic [15:0] inst_pc_q;
    logic [15:0] next_pc_q;
    logic        inst_valid_q;
    logic        halted_q;
    logic        mem_req_q;
    logic [15:0] mem_addr_q;

    logic        xfer;
    logic [15:0] pc_inc;

    assign xfer   = mem_req_q & bus.mem_ready;
    assign pc_inc = pc_q + 16'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            // A request is already outstanding in the first cycle after reset;
            // any byte pending from before reset is simply dropped.
            state_q      <= FETCH_OP;
            pc_q         <= RESET_PC;
            inst_q       <= 16'h0000;
            inst_pc_q    <= RESET_PC;
            next_pc_q    <= RESET_PC;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= RESET_PC;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (xfer) begin
                        inst_q[15:8] <= bus.mem_rdata;
                        inst_pc_q    <= pc_q;
                        pc_q         <= pc_inc;
                        if (!bus.mem_rdata[7]) begin
                            inst_q[7:0]  <= 8'h00;
                            next_pc_q    <= pc_inc;
                            inst_valid_q <= 1'b1;
                            mem_req_q    <= 1'b0;
                            state_q      <= HOLD;
                        end else begin
                            // Keep mem_req high so the argument byte can
                            // transfer on the very next edge.
                            mem_addr_q <= pc_inc;
                            state_q    <= FETCH_ARG;
                        end
                    end
                end
                FETCH_ARG: begin
                    if (xfer) begin
                        inst_q[7:0]  <= bus.mem_rdata;
                        pc_q         <= pc_inc;
                        next_pc_q    <= pc_inc;
                        inst_valid_q <= 1'b1;
                        mem_req_q    <= 1'b0;
                        state_q      <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.exec_done) begin
                        inst_valid_q <= 1'b0;
                        if (bus.halt) begin
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else if (bus.redirect) begin
                            pc_q       <= bus.redirect_pc;
                            mem_addr_q <= bus.redirect_pc;
                            mem_req_q  <= 1'b1;
                            state_q    <= FETCH_OP;
                        end else begin
                            mem_addr_q <= pc_q;
                            mem_req_q  <= 1'b1;
                            state_q    <= FETCH_OP;
                        end
                    end
                end
                default: begin
                    // HALTED: only reset leaves this state.
                    mem_req_q    <= 1'b0;
                    inst_valid_q <= 1'b0;
                    halted_q     <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] perf_inst_q;
    logic [15:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_inst_q  <= 16'h0000;
            perf_stall_q <= 16'h0000;
        end else begin
            if (state_q == HOLD && bus.exec_done) begin
                perf_inst_q <= perf_inst_q + 16'd1;
            end
            if (mem_req_q && !bus.mem_ready) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_inst_count_o  = perf_inst_q;
    assign perf_stall_count_o = perf_stall_q;
`endif

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.next_pc    = next_pc_q;
    assign bus.halted     = halted_q;
    assign dbg_state_o    = state_q;

endmodule
